// File: rtl/siggen_pkg.sv
// rtl/siggen_pkg.sv - shared widths and capture FSM state type for the signal generator slice
package siggen_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port capture memory, one write port, read-first registered read port
module capture_ram
    import siggen_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [ADDRESS_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [ADDRESS_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is left unreset so it maps onto block RAM; only the read register clears.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - level-crossing triggered window capture; AUTO_TRIG_EN adds a timeout-forced trigger
module scope_capture
    import siggen_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int AUTO_TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     arm,
    input  logic [DATA_WIDTH-1:0]    level,
    output logic                     busy,
    output logic                     done,
    output logic                     auto_trig,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    capture_state_t             r_state;
    capture_state_t             w_state_next;
    logic [DATA_WIDTH-1:0]      r_prev;
    logic                       r_prev_valid;
    logic [ADDRESS_WIDTH-1:0]   r_wr_ptr;
    logic                       w_crossing;
    logic                       w_forced;
    logic                       w_trigger;
    logic                       w_we;
    logic [ADDRESS_WIDTH-1:0]   w_waddr;
    logic                       w_rearm;

    // The first sample after arming only seeds r_prev, so it can never be a crossing.
    assign w_crossing = r_prev_valid && (r_prev < level) && (din >= level);
    assign w_trigger  = w_crossing || w_forced;
    assign w_rearm    = ((r_state == IDLE) || (r_state == DONE)) && arm;

    assign busy = (r_state == ARMED) || (r_state == CAPTURE);
    assign done = (r_state == DONE);

`ifdef AUTO_TRIG_EN
    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(AUTO_TIMEOUT - 1);

    logic [CNT_W-1:0] r_timeout_cnt;
    logic             r_auto_flag;

    // The sample that brings the count to AUTO_TIMEOUT is the forced trigger.
    assign w_forced  = (r_timeout_cnt == TIMEOUT_LAST);
    assign auto_trig = (r_state == DONE) && r_auto_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_cnt <= '0;
            r_auto_flag   <= 1'b0;
        end else if (w_rearm) begin
            r_timeout_cnt <= '0;
            r_auto_flag   <= 1'b0;
        end else if ((r_state == ARMED) && en) begin
            if (w_trigger) begin
                r_auto_flag <= !w_crossing;
            end else begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
        end
    end
`else
    assign w_forced  = 1'b0;
    assign auto_trig = (AUTO_TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = r_wr_ptr;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (en && w_trigger) begin
                    w_state_next = CAPTURE;
                    w_we         = 1'b1;
                    w_waddr      = '0;
                end
            end
            CAPTURE: begin
                if (en) begin
                    w_we = 1'b1;
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    w_state_next = ARMED;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
        end else begin
            if (w_rearm) begin
                r_prev_valid <= 1'b0;
            end
            if ((r_state == ARMED) && en) begin
                if (w_trigger) begin
                    r_wr_ptr <= ADDRESS_WIDTH'(1);
                end else begin
                    r_prev       <= din;
                    r_prev_valid <= 1'b1;
                end
            end
            // Pointer wraps to 0 after the last write and sits idle until the next trigger.
            if ((r_state == CAPTURE) && en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    capture_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (din),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule
